// File: rtl/bp_pkg.sv
`default_nettype none
// =============================================================================
// Module   : bp_pkg
// Purpose  : Shared definitions for the gshare branch predictor: FSM state
//            encodings, default parameter values and the saturating-counter
//            next-value helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// =============================================================================
package bp_pkg;

   localparam int c_DEF_INDEX_BITS = 4;
   localparam int c_DEF_CTR_BITS   = 2;
   localparam int c_DEF_HIST_BITS  = 4;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } bp_state_t;

   // Next value of a ctr_bits-wide saturating counter, carried in 32 bits so
   // one function serves every counter width.
   function automatic logic [31:0] sat_ctr_next(
      input logic [31:0] ctr,
      input logic        taken,
      input int          ctr_bits
   );
      logic [31:0] max_val;
      max_val = (32'd1 << ctr_bits) - 32'd1;
      if (taken) begin
         return (ctr >= max_val) ? max_val : ctr + 32'd1;
      end
      return (ctr == 32'd0) ? 32'd0 : ctr - 32'd1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/bp_pht.sv
`default_nettype none
// =============================================================================
// Module   : bp_pht
// Purpose  : Pattern history table of 2^INDEX_BITS saturating counters.
//            One synchronous read port, one write port. A write either loads
//            i_wr_data (init sweep) or steps the addressed counter up/down.
//            Reads return the value from before a same-cycle write.
// Ports    : clk, rst (async, active-high; clears only the read register)
//            i_rd_en, i_rd_addr -> o_rd_data (registered, holds when idle)
//            i_wr_en, i_wr_addr, i_wr_load, i_wr_data, i_wr_taken
// Revision : 1.0 - initial release
// =============================================================================
module bp_pht
   import bp_pkg::*;
#(
   parameter int INDEX_BITS = c_DEF_INDEX_BITS,
   parameter int CTR_BITS   = c_DEF_CTR_BITS
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_rd_en,
   input  logic [INDEX_BITS-1:0] i_rd_addr,
   output logic [CTR_BITS-1:0]   o_rd_data,
   input  logic                  i_wr_en,
   input  logic [INDEX_BITS-1:0] i_wr_addr,
   input  logic                  i_wr_load,
   input  logic [CTR_BITS-1:0]   i_wr_data,
   input  logic                  i_wr_taken
);

   localparam int c_DEPTH = 1 << INDEX_BITS;

   logic [CTR_BITS-1:0] r_mem [c_DEPTH];
   logic [CTR_BITS-1:0] r_rd_data;
   logic [CTR_BITS-1:0] w_wr_value;

   always_comb begin
      w_wr_value = i_wr_data;
      if (!i_wr_load) begin
         w_wr_value = CTR_BITS'(sat_ctr_next(32'(r_mem[i_wr_addr]), i_wr_taken, CTR_BITS));
      end
   end

   // The table itself is never reset; the init sweep fills it instead.
   always_ff @(posedge clk) begin
      if (i_wr_en) begin
         r_mem[i_wr_addr] <= w_wr_value;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rd_data <= '0;
      end else if (i_rd_en) begin
         r_rd_data <= r_mem[i_rd_addr];
      end
   end

   assign o_rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/gshare_branch_predictor.sv
`default_nettype none
// =============================================================================
// Module   : gshare_branch_predictor
// Purpose  : Gshare predictor. A PHT of saturating counters is indexed by
//            PC[INDEX_BITS+1:2] XOR a non-speculative global history register.
//            After reset an init sweep writes every counter to weakly-taken;
//            ready rises when it completes and requests are ignored until then.
// Ports    : clk, reset (async, active-high), ready
//            lookup_valid, lookup_pc -> pred_valid, pred_taken, pred_index
//            upd_valid, upd_index, upd_taken, upd_mispredict
//            stat_lookups, stat_mispredicts (BP_STATS_EN only)
// Macros   : BP_STATS_EN - adds saturating lookup / mispredict counters.
// Revision : 1.0 - initial release
// =============================================================================
module gshare_branch_predictor
   import bp_pkg::*;
#(
   parameter int INDEX_BITS = c_DEF_INDEX_BITS,
   parameter int CTR_BITS   = c_DEF_CTR_BITS,
   parameter int HIST_BITS  = c_DEF_HIST_BITS
) (
   input  logic                  clk,
   input  logic                  reset,
   output logic                  ready,
   input  logic                  lookup_valid,
   input  logic [31:0]           lookup_pc,
   output logic                  pred_valid,
   output logic                  pred_taken,
   output logic [INDEX_BITS-1:0] pred_index,
   input  logic                  upd_valid,
   input  logic [INDEX_BITS-1:0] upd_index,
   input  logic                  upd_taken,
   input  logic                  upd_mispredict
`ifdef BP_STATS_EN
   ,
   output logic [31:0]           stat_lookups,
   output logic [31:0]           stat_mispredicts
`endif
);

   localparam logic [CTR_BITS-1:0]   c_CTR_INIT   = CTR_BITS'(1) << (CTR_BITS - 1);
   localparam logic [INDEX_BITS-1:0] c_LAST_ENTRY = '1;

   bp_state_t             r_state;
   bp_state_t             w_state_next;
   logic [INDEX_BITS-1:0] r_init_ptr;
   logic [INDEX_BITS-1:0] r_pred_index;
   logic                  r_pred_valid;
   logic [HIST_BITS-1:0]  r_ghr;
   logic [HIST_BITS-1:0]  w_ghr_next;
   logic [INDEX_BITS-1:0] w_ghr_ext;
   logic [INDEX_BITS-1:0] w_lk_index;
   logic                  w_init;
   logic                  w_lk_acc;
   logic                  w_upd_acc;
   logic                  w_wr_en;
   logic [INDEX_BITS-1:0] w_wr_addr;
   logic [CTR_BITS-1:0]   w_rd_data;

   assign w_init    = (r_state == ST_INIT);
   assign w_lk_acc  = lookup_valid & ~w_init;
   assign w_upd_acc = upd_valid & ~w_init;

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_INIT;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_INIT: if (r_init_ptr == c_LAST_ENTRY) w_state_next = ST_RUN;
         ST_RUN:  w_state_next = ST_RUN;
         default: w_state_next = ST_INIT;
      endcase
   end

   // ---------------------------------------------------------------- index hash
   always_comb begin
      w_ghr_ext                  = '0;
      w_ghr_ext[HIST_BITS-1:0]   = r_ghr;
   end

   assign w_lk_index = lookup_pc[INDEX_BITS+1:2] ^ w_ghr_ext;

   generate
      if (HIST_BITS == 1) begin : g_ghr_single
         assign w_ghr_next = upd_taken;
      end else begin : g_ghr_shift
         assign w_ghr_next = {r_ghr[HIST_BITS-2:0], upd_taken};
      end
   endgenerate

   // ---------------------------------------------------------------- state regs
   // A lookup in the same cycle as an update hashes with the pre-shift GHR
   // because both read r_ghr before this edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_init_ptr   <= '0;
         r_ghr        <= '0;
         r_pred_valid <= 1'b0;
         r_pred_index <= '0;
      end else begin
         if (w_init) begin
            r_init_ptr <= r_init_ptr + INDEX_BITS'(1);
         end
         if (w_upd_acc) begin
            r_ghr <= w_ghr_next;
         end
         r_pred_valid <= w_lk_acc;
         if (w_lk_acc) begin
            r_pred_index <= w_lk_index;
         end
      end
   end

   // ---------------------------------------------------------------- PHT
   // Sweep and updates share the write port; they never overlap because
   // updates are only accepted outside INIT.
   assign w_wr_en   = w_init | w_upd_acc;
   assign w_wr_addr = w_init ? r_init_ptr : upd_index;

   bp_pht #(
      .INDEX_BITS (INDEX_BITS),
      .CTR_BITS   (CTR_BITS)
   ) u_pht (
      .clk        (clk),
      .rst        (reset),
      .i_rd_en    (w_lk_acc),
      .i_rd_addr  (w_lk_index),
      .o_rd_data  (w_rd_data),
      .i_wr_en    (w_wr_en),
      .i_wr_addr  (w_wr_addr),
      .i_wr_load  (w_init),
      .i_wr_data  (c_CTR_INIT),
      .i_wr_taken (upd_taken)
   );

   assign ready      = ~w_init;
   assign pred_valid = r_pred_valid;
   assign pred_taken = w_rd_data[CTR_BITS-1];
   assign pred_index = r_pred_index;

   // ---------------------------------------------------------------- statistics
`ifdef BP_STATS_EN
   logic [31:0] r_stat_lookups;
   logic [31:0] r_stat_mispredicts;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_stat_lookups     <= '0;
         r_stat_mispredicts <= '0;
      end else begin
         if (w_lk_acc && (r_stat_lookups != 32'hFFFF_FFFF)) begin
            r_stat_lookups <= r_stat_lookups + 32'd1;
         end
         if (w_upd_acc && upd_mispredict && (r_stat_mispredicts != 32'hFFFF_FFFF)) begin
            r_stat_mispredicts <= r_stat_mispredicts + 32'd1;
         end
      end
   end

   assign stat_lookups     = r_stat_lookups;
   assign stat_mispredicts = r_stat_mispredicts;

   // Only the index slice of the PC and the counter MSB feed the datapath.
   logic w_unused;
   assign w_unused = ^{lookup_pc, w_rd_data};
`else
   logic w_unused;
   assign w_unused = ^{lookup_pc, w_rd_data, upd_mispredict};
`endif

endmodule
`default_nettype wire

// File: tb/tb_gshare_branch_predictor.sv
`default_nettype none
// =============================================================================
// Module   : tb_gshare_branch_predictor
// Purpose  : Self-checking bench for gshare_branch_predictor. A behavioural
//            PHT/GHR model predicts each lookup result into a scoreboard queue
//            that is drained as pred_valid pulses arrive.
// Macros   : BP_STATS_EN - also checks the statistics counters.
// Revision : 1.0 - initial release
// =============================================================================
module tb_gshare_branch_predictor;

   localparam int IB = 4;
   localparam int CB = 2;
   localparam int HB = 4;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          ready;
   logic          lookup_valid = 1'b0;
   logic [31:0]   lookup_pc = '0;
   logic          pred_valid;
   logic          pred_taken;
   logic [IB-1:0] pred_index;
   logic          upd_valid = 1'b0;
   logic [IB-1:0] upd_index = '0;
   logic          upd_taken = 1'b0;
   logic          upd_mispredict = 1'b0;
`ifdef BP_STATS_EN
   logic [31:0]   stat_lookups;
   logic [31:0]   stat_mispredicts;
`endif

   always #5 clk = ~clk;

   gshare_branch_predictor #(
      .INDEX_BITS (IB),
      .CTR_BITS   (CB),
      .HIST_BITS  (HB)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .ready          (ready),
      .lookup_valid   (lookup_valid),
      .lookup_pc      (lookup_pc),
      .pred_valid     (pred_valid),
      .pred_taken     (pred_taken),
      .pred_index     (pred_index),
      .upd_valid      (upd_valid),
      .upd_index      (upd_index),
      .upd_taken      (upd_taken),
      .upd_mispredict (upd_mispredict)
`ifdef BP_STATS_EN
      ,
      .stat_lookups     (stat_lookups),
      .stat_mispredicts (stat_mispredicts)
`endif
   );

   typedef struct packed {
      logic          taken;
      logic [IB-1:0] idx;
   } exp_t;

   exp_t          sb_q[$];
   int            n_vec = 0;
   int            n_err = 0;
   int            mdl_pht[16];
   logic [HB-1:0] mdl_ghr = '0;
   logic          mdl_ready = 1'b0;

   task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Scoreboard drain: one expected entry per pred_valid pulse.
   always @(negedge clk) begin
      exp_t e;
      if (pred_valid === 1'b1) begin
         if (sb_q.size() == 0) begin
            chk_val("unexpected_pred", 32'd1, 32'd0);
         end else begin
            e = sb_q.pop_front();
            chk_val("pred_taken", 32'(pred_taken), 32'(e.taken));
            chk_val("pred_index", 32'(pred_index), 32'(e.idx));
         end
      end
   end

   function automatic logic [31:0] pc_for(input logic [IB-1:0] idx);
      logic [31:0] pc;
      pc      = $urandom;
      pc[5:2] = idx ^ mdl_ghr;
      return pc;
   endfunction

   // Drive one cycle of stimulus; the model sees a lookup before a
   // same-cycle update (read-before-write, pre-shift GHR).
   task automatic cycle(input logic lv, input logic [31:0] pc, input logic uv,
                        input logic [IB-1:0] uidx, input logic ut, input logic um);
      exp_t e;
      lookup_valid   = lv;
      lookup_pc      = pc;
      upd_valid      = uv;
      upd_index      = uidx;
      upd_taken      = ut;
      upd_mispredict = um;
      if (mdl_ready) begin
         if (lv) begin
            e.idx   = pc[5:2] ^ mdl_ghr;
            e.taken = (mdl_pht[e.idx] >= 2);
            sb_q.push_back(e);
         end
         if (uv) begin
            if (ut) mdl_pht[uidx] = (mdl_pht[uidx] == 3) ? 3 : mdl_pht[uidx] + 1;
            else    mdl_pht[uidx] = (mdl_pht[uidx] == 0) ? 0 : mdl_pht[uidx] - 1;
            mdl_ghr = {mdl_ghr[HB-2:0], ut};
         end
      end
      @(posedge clk);
      #1;
      lookup_valid = 1'b0;
      upd_valid    = 1'b0;
   endtask

   task automatic lookup(input logic [31:0] pc);
      cycle(1'b1, pc, 1'b0, '0, 1'b0, 1'b0);
   endtask

   task automatic update(input logic [IB-1:0] idx, input logic t, input logic m);
      cycle(1'b0, 32'd0, 1'b1, idx, t, m);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 32'd0, 1'b0, '0, 1'b0, 1'b0);
   endtask

   // Reset, optionally re-reset after abort_at INIT cycles, then walk the
   // sweep with lookups and mispredicted updates held high throughout.
   task automatic reset_and_init(input int abort_at);
      reset          = 1'b1;
      lookup_valid   = 1'b1;
      lookup_pc      = 32'h0000_0020;
      upd_valid      = 1'b1;
      upd_index      = '0;
      upd_taken      = 1'b1;
      upd_mispredict = 1'b1;
      mdl_ready      = 1'b0;
      mdl_ghr        = '0;
      for (int i = 0; i < 16; i++) mdl_pht[i] = 2;
      @(posedge clk);
      #1;
      chk_val("rst_ready", 32'(ready), 32'd0);
      chk_val("rst_pred_valid", 32'(pred_valid), 32'd0);
      chk_val("rst_pred_taken", 32'(pred_taken), 32'd0);
      chk_val("rst_pred_index", 32'(pred_index), 32'd0);
      sb_q.delete();
      #2 reset = 1'b0;
      if (abort_at > 0) begin
         for (int k = 0; k < abort_at; k++) begin
            @(posedge clk);
            #1;
            chk_val("abort_ready", 32'(ready), 32'd0);
         end
         #2 reset = 1'b1;
         @(posedge clk);
         #1;
         chk_val("abort_rst_ready", 32'(ready), 32'd0);
         #2 reset = 1'b0;
      end
      for (int k = 1; k <= 16; k++) begin
         @(posedge clk);
         #1;
         chk_val("init_ready", 32'(ready), (k == 16) ? 32'd1 : 32'd0);
         chk_val("init_pred_valid", 32'(pred_valid), 32'd0);
      end
      lookup_valid = 1'b0;
      upd_valid    = 1'b0;
      mdl_ready    = 1'b1;
   endtask

   task automatic sweep_all_pcs();
      for (int p = 0; p < 16; p++) lookup(32'(p * 4));
      idle(2);
   endtask

   initial begin
      reset_and_init(0);
      sweep_all_pcs();

      // Outputs hold after the last lookup (PC 0x3C, GHR 0 -> index 15).
      chk_val("hold_valid", 32'(pred_valid), 32'd0);
      chk_val("hold_index", 32'(pred_index), 32'd15);
      chk_val("hold_taken", 32'(pred_taken), 32'd1);

      // Training on index 2, including saturation at both ends.
      update(4'd2, 1'b0, 1'b0);
      update(4'd2, 1'b0, 1'b0);
      lookup(pc_for(4'd2));
      update(4'd2, 1'b0, 1'b0);
      lookup(pc_for(4'd2));
      update(4'd2, 1'b1, 1'b0);
      lookup(pc_for(4'd2));
      update(4'd2, 1'b1, 1'b0);
      update(4'd2, 1'b1, 1'b0);
      lookup(pc_for(4'd2));
      update(4'd2, 1'b1, 1'b0);
      update(4'd2, 1'b0, 1'b0);
      update(4'd2, 1'b0, 1'b0);
      lookup(pc_for(4'd2));
      idle(2);

      // GHR hashing: history 1,0,1,1 -> 4'b1011; PC 0x14 -> index 4'b1110.
      update(4'd9, 1'b1, 1'b0);
      update(4'd9, 1'b0, 1'b0);
      update(4'd9, 1'b1, 1'b0);
      update(4'd9, 1'b1, 1'b0);
      lookup(32'h0000_0014);
      idle(1);
      chk_val("ghr_hash_index", 32'(pred_index), 32'hE);

      // Simultaneous lookup and update to the same index.
      update(4'd5, 1'b0, 1'b0);
      cycle(1'b1, pc_for(4'd5), 1'b1, 4'd5, 1'b0, 1'b0);
      lookup(pc_for(4'd5));
      cycle(1'b1, pc_for(4'd6), 1'b1, 4'd6, 1'b0, 1'b0);
      lookup(pc_for(4'd6));
      update(4'd7, 1'b0, 1'b0);
      cycle(1'b1, pc_for(4'd7), 1'b1, 4'd7, 1'b1, 1'b0);
      lookup(pc_for(4'd7));
      idle(2);

      // Mixed random traffic.
      for (int i = 0; i < 60; i++) begin
         cycle(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
               4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      idle(2);

      // Reset during RUN with trained counters, then mid-INIT.
      reset_and_init(0);
      sweep_all_pcs();
      update(4'd3, 1'b0, 1'b0);
      update(4'd3, 1'b0, 1'b0);
      idle(1);
      reset_and_init(7);
      sweep_all_pcs();

`ifdef BP_STATS_EN
      reset_and_init(0);
      for (int i = 0; i < 5; i++) lookup(32'(i * 4));
      update(4'd1, 1'b0, 1'b1);
      update(4'd2, 1'b1, 1'b0);
      update(4'd3, 1'b0, 1'b1);
      update(4'd4, 1'b1, 1'b0);
      update(4'd5, 1'b1, 1'b1);
      idle(2);
      chk_val("stat_lookups", stat_lookups, 32'd5);
      chk_val("stat_mispredicts", stat_mispredicts, 32'd3);
`endif

      idle(3);
      chk_val("sb_drained", 32'(sb_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
